// File: rtl/throttle_pkg.sv
// Shared types and helpers for the pushbutton clock throttle.
package throttle_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_IDLE = 2'd1,
    STEP_HIGH = 2'd2
  } state_e;

  // Button slots in the debouncer instance array.
  localparam int BTN_UP   = 0;
  localparam int BTN_DN   = 1;
  localparam int BTN_STEP = 2;
  localparam int NUM_BTN  = 3;

  // Half-period in system clocks; each level down doubles it.
  function automatic int unsigned half_period(input int unsigned level,
                                              input int unsigned num_levels,
                                              input int unsigned base_half);
    return base_half << (num_levels - 1 - level);
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
module pb_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK_50,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the
  // debounced value; any agreeing sample restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = s2_q;
        press_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/throttle_ctrl.sv
// Pushbutton clock throttle: NUM_LEVELS binary-spaced rates, free-run or single-step.
module throttle_ctrl
  import throttle_pkg::*;
#(
  parameter  int unsigned NUM_LEVELS      = 8,
  parameter  int unsigned BASE_HALF       = 25000,
  parameter  int unsigned DEBOUNCE_CYCLES = 500000,
  parameter  int unsigned RESET_LEVEL     = 0,
  localparam int unsigned LEVEL_W         = $clog2(NUM_LEVELS)
) (
  input  logic               CLK_50,
  input  logic               reset_n,
  input  logic               pb_freq_up,
  input  logic               pb_freq_dn,
  input  logic               pb_step,
  input  logic               run_mode,
  output logic               slow_clk,
  output logic               tick,
  output logic [LEVEL_W-1:0] freq_num,
  output logic               at_max,
  output logic               at_min
);

  localparam int unsigned MAX_HALF = BASE_HALF << (NUM_LEVELS - 1);
  localparam int unsigned CNT_W    = $clog2(MAX_HALF);
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LEVEL_W-1:0] LVL_RST = LEVEL_W'(RESET_LEVEL);

  logic [NUM_BTN-1:0] btn_raw, btn_press, lvl_unused;

  assign btn_raw = {pb_step, pb_freq_dn, pb_freq_up};

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb [NUM_BTN-1:0] (
    .CLK_50  (CLK_50),
    .reset_n (reset_n),
    .raw     (btn_raw),
    .level   (lvl_unused),
    .press   (btn_press)
  );

  // Sync resets to 1 so a release with run_mode high never dips into step mode.
  logic rm_s1_q, rm_s2_q;

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rm_s1_q <= 1'b1;
      rm_s2_q <= 1'b1;
    end else begin
      rm_s1_q <= run_mode;
      rm_s2_q <= rm_s1_q;
    end
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, half_m1;
  logic [LEVEL_W-1:0] freq_q, freq_d;
  logic               slow_q, slow_d, tick_q, tick_d;
  logic               up_p, dn_p, step_p, inc, dec, lvl_chg, cnt_wrap;

  always_comb begin
    up_p    = btn_press[BTN_UP];
    dn_p    = btn_press[BTN_DN];
    step_p  = btn_press[BTN_STEP];
    inc     = up_p & ~dn_p & (freq_q != LVL_MAX);
    dec     = dn_p & ~up_p & (freq_q != '0);
    lvl_chg = inc | dec;
    freq_d  = freq_q;
    if (inc) freq_d = freq_q + 1'b1;
    if (dec) freq_d = freq_q - 1'b1;
    half_m1  = CNT_W'(half_period(32'(freq_q), NUM_LEVELS, BASE_HALF) - 1);
    cnt_wrap = (cnt_q == half_m1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slow_d  = slow_q;
    tick_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (!rm_s2_q) begin
          state_d = STEP_IDLE;
          cnt_d   = '0;
          slow_d  = 1'b0;
        end else if (lvl_chg) begin
          // New rate starts from a clean low phase; a high phase drops tick-free.
          cnt_d  = '0;
          slow_d = 1'b0;
        end else if (cnt_wrap) begin
          cnt_d  = '0;
          slow_d = ~slow_q;
          tick_d = ~slow_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STEP_IDLE: begin
        cnt_d  = '0;
        slow_d = 1'b0;
        if (rm_s2_q) begin
          state_d = RUN;
        end else if (step_p) begin
          state_d = STEP_HIGH;
          slow_d  = 1'b1;
          tick_d  = 1'b1;
        end
      end
      STEP_HIGH: begin
        if (rm_s2_q) begin
          state_d = RUN;
          cnt_d   = '0;
          slow_d  = 1'b0;
        end else if (lvl_chg) begin
          cnt_d = '0;
        end else if (cnt_wrap) begin
          state_d = STEP_IDLE;
          cnt_d   = '0;
          slow_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        slow_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      freq_q  <= LVL_RST;
      slow_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      slow_q  <= slow_d;
      tick_q  <= tick_d;
    end
  end

  assign slow_clk = slow_q;
  assign tick     = tick_q;
  assign freq_num = freq_q;
  assign at_max   = (freq_q == LVL_MAX);
  assign at_min   = (freq_q == '0);

endmodule

// File: tb/tb_throttle_ctrl.sv
// Directed bench for throttle_ctrl: NUM_LEVELS=4, BASE_HALF=2, DEBOUNCE_CYCLES=4.
module tb_throttle_ctrl;

  logic       clk, reset_n, pb_up, pb_dn, pb_step, run_mode;
  logic       slow_clk, tick, at_max, at_min;
  logic [1:0] freq_num;

  int checks = 0;
  int errors = 0;

  throttle_ctrl #(
    .NUM_LEVELS(4), .BASE_HALF(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(0)
  ) dut (
    .CLK_50(clk), .reset_n(reset_n), .pb_freq_up(pb_up), .pb_freq_dn(pb_dn),
    .pb_step(pb_step), .run_mode(run_mode), .slow_clk(slow_clk), .tick(tick),
    .freq_num(freq_num), .at_max(at_max), .at_min(at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // 0=up 1=down 2=up+down together; held 10 cycles, then settle 12.
  task automatic pulse(input int which);
    pb_up = (which == 0 || which == 2);
    pb_dn = (which == 1 || which == 2);
    repeat (10) @(negedge clk);
    pb_up = 1'b0;
    pb_dn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (tick !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) chk({tag, "_timeout"}, n, 0);
  endtask

  // Align to a tick, then measure period and high time up to the next tick.
  task automatic meas(input string tag, input int per_exp);
    int n = 0;
    int hi = 0;
    wait_tick(tag);
    chk({tag, "_rise"}, slow_clk, 1);
    do begin
      if (slow_clk) hi++;
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 300);
    chk({tag, "_per"}, n, per_exp);
    chk({tag, "_hi"}, hi, per_exp / 2);
  endtask

  int bad, hi, tk;

  initial begin
    reset_n = 1'b0; pb_up = 1'b0; pb_dn = 1'b0; pb_step = 1'b0; run_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_slow", slow_clk, 0);
    chk("rst_tick", tick, 0);
    chk("rst_freq", freq_num, 0);
    chk("rst_min", at_min, 1);
    chk("rst_max", at_max, 0);

    // 1: free-run at level 0, first rise after 16 cycles
    reset_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (tick || slow_clk) bad++;
    end
    chk("s1_low_phase", bad, 0);
    @(negedge clk);
    chk("s1_first_tick", tick, 1);
    meas("s1_l0", 32);

    // 2: up presses to saturation
    pulse(0); chk("s2_freq1", freq_num, 1); meas("s2_l1", 16);
    pulse(0); chk("s2_freq2", freq_num, 2); meas("s2_l2", 8);
    pulse(0); chk("s2_freq3", freq_num, 3); meas("s2_l3", 4);
    chk("s2_max", at_max, 1);
    chk("s2_min", at_min, 0);
    bad = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 1) pb_up = 1'b1;
      if (i == 11) pb_up = 1'b0;
      if (tick !== ((i % 4) == 0) || freq_num !== 2'd3) bad++;
    end
    chk("s2_sat_phase", bad, 0);
    repeat (12) @(negedge clk);

    // 3: bounce gives one increment 7 cycles after the last edge
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pb_up = ((i % 2) == 0);
      repeat (2) @(negedge clk);
      end
    chk("s3_no_bounce", freq_num, 0);
    pb_up = 1'b1;
    repeat (6) @(negedge clk);
    chk("s3_pre", freq_num, 0);
    @(negedge clk);
    chk("s3_inc", freq_num, 1);
    repeat (4) @(negedge clk);
    pb_up = 1'b0;
    repeat (12) @(negedge clk);
    chk("s3_once", freq_num, 1);
    pulse(2); chk("s3_both", freq_num, 1);
    pulse(0); pulse(0); chk("s3_to3", freq_num, 3);

    // 4: down to saturation, then a change during the high phase
    pulse(1); chk("s4_freq2", freq_num, 2);
    pulse(1); chk("s4_freq1", freq_num, 1);
    pulse(1); chk("s4_freq0", freq_num, 0);
    pulse(1); chk("s4_sat0", freq_num, 0);
    chk("s4_min", at_min, 1);
    wait_tick("s4_align");
    pb_up = 1'b1;
    bad = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (tick || !slow_clk) bad++;
    end
    chk("s4_high_hold", bad, 0);
    @(negedge clk);
    chk("s4_chg_freq", freq_num, 1);
    chk("s4_chg_slow", slow_clk, 0);
    chk("s4_chg_tick", tick, 0);
    bad = 0;
    for (int k = 8; k <= 14; k++) begin
      @(negedge clk);
      if (k == 10) pb_up = 1'b0;
      if (tick || slow_clk) bad++;
    end
    chk("s4_clean_low", bad, 0);
    @(negedge clk);
    chk("s4_new_tick", tick, 1);
    repeat (12) @(negedge clk);

    // 5: single-step at level 2, then at level 0 with an ignored second press
    pulse(0); chk("s5_freq2", freq_num, 2);
    run_mode = 1'b0;
    repeat (5) @(negedge clk);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick || slow_clk) bad++;
    end
    chk("s5_idle_low", bad, 0);
    pb_step = 1'b1;
    bad = 0; hi = 0; tk = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 10) pb_step = 1'b0;
      if (slow_clk !== (k >= 7 && k <= 10) || tick !== (k == 7)) bad++;
      if (slow_clk) hi++;
      if (tick) tk++;
    end
    chk("s5_step_shape", bad, 0);
    chk("s5_step_hi", hi, 4);
    chk("s5_step_ticks", tk, 1);
    repeat (12) @(negedge clk);
    pulse(1); pulse(1); chk("s5_step_lvl0", freq_num, 0);
    pb_step = 1'b1;
    hi = 0; tk = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) pb_step = 1'b0;
      if (k == 10) pb_step = 1'b1;
      if (k == 20) pb_step = 1'b0;
      if (slow_clk) hi++;
      if (tick) tk++;
      if (k == 22) chk("s5_last_high", slow_clk, 1);
      if (k == 23) chk("s5_fall", slow_clk, 0);
    end
    chk("s5_ign_ticks", tk, 1);
    chk("s5_ign_hi", hi, 16);
    run_mode = 1'b1;
    bad = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (tick || slow_clk) bad++;
    end
    chk("s5_resume_low", bad, 0);
    @(negedge clk);
    chk("s5_resume_tick", tick, 1);

    // 6: asynchronous reset in the middle of a step high phase
    pulse(0); chk("s6_freq1", freq_num, 1);
    run_mode = 1'b0;
    repeat (5) @(negedge clk);
    pb_step = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 5) pb_step = 1'b0;
    end
    chk("s6_pre_high", slow_clk, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_slow", slow_clk, 0);
    chk("s6_rst_tick", tick, 0);
    chk("s6_rst_freq", freq_num, 0);
    run_mode = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (tick || slow_clk) bad++;
    end
    chk("s6_run_low", bad, 0);
    @(negedge clk);
    chk("s6_run_tick", tick, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
